// File: rtl/one_hot_mux.sv
// One-hot select mux: ORs together the words whose select bit is set.
// With a one-hot select this passes exactly one word; an all-zero select yields zero.
module one_hot_mux #(
  parameter int NUM_IN = 4,
  parameter int WIDTH  = 16
) (
  input  logic [NUM_IN-1:0]       sel,
  input  logic [NUM_IN*WIDTH-1:0] data_in,
  output logic [WIDTH-1:0]        data_out
);

  always_comb begin
    data_out = '0;
    for (int i = 0; i < NUM_IN; i++) begin
      data_out = data_out | (data_in[i*WIDTH +: WIDTH] & {WIDTH{sel[i]}});
    end
  end

endmodule

// File: rtl/result_bus_arbiter.sv
// Round-robin arbiter sharing one registered result bus between NUM_REQ requesters,
// with a valid/ready handshake on both sides and full single-cycle throughput.
module result_bus_arbiter #(
  parameter int NUM_REQ    = 4,
  parameter int DATA_WIDTH = 16
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic [NUM_REQ-1:0]            req_valid,
  input  logic [NUM_REQ*DATA_WIDTH-1:0] req_data,
  output logic [NUM_REQ-1:0]            req_ready,
  output logic                          out_valid,
  output logic [DATA_WIDTH-1:0]         out_data,
  output logic [NUM_REQ-1:0]            out_src,
  input  logic                          out_ready
);

  localparam int PTR_W = $clog2(NUM_REQ);

  typedef enum logic {EMPTY, FULL} state_t;

  state_t                 state;
  logic [PTR_W-1:0]       ptr;
  logic [2*NUM_REQ-1:0]   valid_dbl;
  logic [2*NUM_REQ-1:0]   grant_dbl;
  logic [NUM_REQ-1:0]     rot_valid;
  logic [NUM_REQ-1:0]     rot_grant;
  logic [NUM_REQ-1:0]     grant;
  logic [PTR_W:0]         rot_idx;
  logic [PTR_W:0]         idx_sum;
  logic [PTR_W-1:0]       grant_idx;
  logic [PTR_W-1:0]       next_ptr;
  logic [DATA_WIDTH-1:0]  mux_data;
  logic                   load;

  assign out_valid = (state == FULL);

  // Rotate so ptr sits at bit 0, isolate the lowest pending bit, rotate back.
  always_comb begin
    valid_dbl = {req_valid, req_valid} >> ptr;
    rot_valid = valid_dbl[NUM_REQ-1:0];
    rot_grant = rot_valid & (~rot_valid + NUM_REQ'(1));
    grant_dbl = {rot_grant, rot_grant} << ptr;
    grant     = grant_dbl[2*NUM_REQ-1:NUM_REQ];

    rot_idx = '0;
    for (int i = NUM_REQ - 1; i >= 0; i--) begin
      if (rot_valid[i]) rot_idx = (PTR_W+1)'(i);
    end
    idx_sum = {1'b0, ptr} + rot_idx;
    if (idx_sum >= (PTR_W+1)'(NUM_REQ)) grant_idx = PTR_W'(idx_sum - (PTR_W+1)'(NUM_REQ));
    else                                grant_idx = PTR_W'(idx_sum);
    if (grant_idx == PTR_W'(NUM_REQ - 1)) next_ptr = '0;
    else                                  next_ptr = grant_idx + PTR_W'(1);
  end

  assign load      = (|req_valid) && (!out_valid || out_ready);
  assign req_ready = (load && !rst) ? grant : '0;

  one_hot_mux #(
    .NUM_IN (NUM_REQ),
    .WIDTH  (DATA_WIDTH)
  ) u_mux (
    .sel      (grant),
    .data_in  (req_data),
    .data_out (mux_data)
  );

  // A load replaces the held word even while draining it, so no bubble appears.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state    <= EMPTY;
      out_data <= '0;
      out_src  <= '0;
      ptr      <= '0;
    end else if (load) begin
      state    <= FULL;
      out_data <= mux_data;
      out_src  <= grant;
      ptr      <= next_ptr;
    end else if (out_ready && state == FULL) begin
      state    <= EMPTY;
    end
  end

endmodule

// File: tb/tb_result_bus_arbiter.sv
// Self-checking bench for result_bus_arbiter: directed table, reset corners,
// then random traffic against a round-robin reference model and scoreboard.
module tb_result_bus_arbiter;

  localparam int N = 4;
  localparam int W = 3;

  logic           clk = 1'b0;
  logic           rst;
  logic [N-1:0]   req_valid;
  logic [N*W-1:0] req_data;
  logic [N-1:0]   req_ready;
  logic           out_valid;
  logic [W-1:0]   out_data;
  logic [N-1:0]   out_src;
  logic           out_ready;

  int n_vec = 0;
  int n_bad = 0;

  typedef struct {
    logic [W-1:0] d;
    logic [N-1:0] s;
  } exp_t;

  typedef struct {
    logic [N-1:0] rv;
    logic         ordy;
    logic [N-1:0] exp_rr;
    logic         exp_ov;
    logic [W-1:0] exp_od;
    logic [N-1:0] exp_os;
  } row_t;

  exp_t sb[$];
  exp_t held;
  int   m_ptr;
  bit   m_valid;
  row_t tbl[13];
  logic [N-1:0] rr_seen;
  logic [N*W-1:0] base_data;

  result_bus_arbiter #(.NUM_REQ(N), .DATA_WIDTH(W)) dut (
    .clk       (clk),
    .rst       (rst),
    .req_valid (req_valid),
    .req_data  (req_data),
    .req_ready (req_ready),
    .out_valid (out_valid),
    .out_data  (out_data),
    .out_src   (out_src),
    .out_ready (out_ready)
  );

  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, got timeout required $finish");
    $fatal(1, "[TB] watchdog expired");
  end

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_bad++;
      $display("[TB] FAIL %s: got %0h required %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference search: walk forward from the pointer until a pending requester is found.
  function automatic int modelGrant(input logic [N-1:0] rv);
    for (int k = 0; k < N; k++) begin
      if (rv[(m_ptr + k) % N]) return (m_ptr + k) % N;
    end
    return -1;
  endfunction

  // Called just after a rising edge; returns just after the next rising edge.
  task automatic applyStimulus(input logic [N-1:0] rv, input logic ordy,
                               input logic [N*W-1:0] rd, output logic [N-1:0] rr);
    int   g;
    bit   ld;
    exp_t e;
    logic [N-1:0] exp_rr;
    req_valid = rv;
    out_ready = ordy;
    req_data  = rd;
    @(negedge clk);
    g      = modelGrant(rv);
    ld     = (g >= 0) && (!m_valid || ordy);
    exp_rr = ld ? N'(1 << g) : '0;
    checkOutput("req_ready", 32'(req_ready), 32'(exp_rr));
    rr = req_ready;
    if (ld) begin
      e.d = rd[g*W +: W];
      e.s = N'(1 << g);
      sb.push_back(e);
    end
    @(posedge clk);
    #1;
    if (ld) begin
      held    = sb.pop_front();
      m_valid = 1'b1;
      m_ptr   = (g + 1) % N;
    end else if (m_valid && ordy) begin
      m_valid = 1'b0;
    end
    checkOutput("out_valid", 32'(out_valid), 32'(m_valid));
    checkOutput("out_data", 32'(out_data), 32'(held.d));
    checkOutput("out_src", 32'(out_src), 32'(held.s));
  endtask

  task automatic modelReset();
    m_ptr   = 0;
    m_valid = 1'b0;
    held.d  = '0;
    held.s  = '0;
    sb.delete();
  endtask

  // Assert reset mid-cycle and confirm the register clears before any clock edge.
  task automatic asyncReset(input logic [N-1:0] rv);
    req_valid = rv;
    out_ready = 1'b1;
    rst = 1'b1;
    #1;
    checkOutput("async_out_valid", 32'(out_valid), 32'(0));
    checkOutput("async_out_src", 32'(out_src), 32'(0));
    checkOutput("async_out_data", 32'(out_data), 32'(0));
    checkOutput("async_req_ready", 32'(req_ready), 32'(0));
    @(posedge clk);
    #1;
    rst = 1'b0;
    modelReset();
  endtask

  initial begin
    base_data = 12'b000_001_010_011;
    rst       = 1'b1;
    req_valid = 4'b1111;
    req_data  = base_data;
    out_ready = 1'b1;
    modelReset();

    tbl[0]  = '{4'b1111, 1'b1, 4'b0001, 1'b1, 3'b011, 4'b0001};
    tbl[1]  = '{4'b1111, 1'b1, 4'b0010, 1'b1, 3'b010, 4'b0010};
    tbl[2]  = '{4'b1111, 1'b1, 4'b0100, 1'b1, 3'b001, 4'b0100};
    tbl[3]  = '{4'b1111, 1'b1, 4'b1000, 1'b1, 3'b000, 4'b1000};
    tbl[4]  = '{4'b1111, 1'b1, 4'b0001, 1'b1, 3'b011, 4'b0001};
    tbl[5]  = '{4'b1010, 1'b0, 4'b0000, 1'b1, 3'b011, 4'b0001};
    tbl[6]  = '{4'b1010, 1'b0, 4'b0000, 1'b1, 3'b011, 4'b0001};
    tbl[7]  = '{4'b1010, 1'b0, 4'b0000, 1'b1, 3'b011, 4'b0001};
    tbl[8]  = '{4'b1010, 1'b1, 4'b0010, 1'b1, 3'b010, 4'b0010};
    tbl[9]  = '{4'b0000, 1'b1, 4'b0000, 1'b0, 3'b010, 4'b0010};
    tbl[10] = '{4'b1000, 1'b1, 4'b1000, 1'b1, 3'b000, 4'b1000};
    tbl[11] = '{4'b1001, 1'b1, 4'b0001, 1'b1, 3'b011, 4'b0001};
    tbl[12] = '{4'b0000, 1'b0, 4'b0000, 1'b1, 3'b011, 4'b0001};

    // Reset held with every requester pending: nothing is offered or registered.
    @(posedge clk);
    #1;
    checkOutput("rst_req_ready", 32'(req_ready), 32'(0));
    checkOutput("rst_out_valid", 32'(out_valid), 32'(0));
    checkOutput("rst_out_data", 32'(out_data), 32'(0));
    checkOutput("rst_out_src", 32'(out_src), 32'(0));
    rst = 1'b0;

    for (int i = 0; i < 13; i++) begin
      applyStimulus(tbl[i].rv, tbl[i].ordy, base_data, rr_seen);
      checkOutput($sformatf("tbl%0d_req_ready", i), 32'(rr_seen), 32'(tbl[i].exp_rr));
      checkOutput($sformatf("tbl%0d_out_valid", i), 32'(out_valid), 32'(tbl[i].exp_ov));
      checkOutput($sformatf("tbl%0d_out_data", i), 32'(out_data), 32'(tbl[i].exp_od));
      checkOutput($sformatf("tbl%0d_out_src", i), 32'(out_src), 32'(tbl[i].exp_os));
    end

    asyncReset(4'b0000);

    // Lone requester 2 from reset, then all pending: pointer must now favour 3.
    applyStimulus(4'b0100, 1'b1, base_data, rr_seen);
    checkOutput("solo_req_ready", 32'(rr_seen), 32'(4'b0100));
    checkOutput("solo_out_data", 32'(out_data), 32'(3'b001));
    checkOutput("solo_out_src", 32'(out_src), 32'(4'b0100));
    applyStimulus(4'b1111, 1'b1, base_data, rr_seen);
    checkOutput("ptr3_req_ready", 32'(rr_seen), 32'(4'b1000));

    asyncReset(4'b1111);
    applyStimulus(4'b1111, 1'b1, base_data, rr_seen);
    checkOutput("post_rst_req_ready", 32'(rr_seen), 32'(4'b0001));
    checkOutput("post_rst_out_src", 32'(out_src), 32'(4'b0001));

    for (int i = 0; i < 400; i++) begin
      applyStimulus(N'($urandom_range(0, 15)), ($urandom_range(0, 3) != 0),
                    (N*W)'($urandom), rr_seen);
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
